// File: rtl/sul_jump_engine_pkg.sv
// sul_jump_engine_pkg: shared board geometry, hop counter width and FSM states for the up-left jump engine
package sul_jump_engine_pkg;
    localparam int BOARD_W = 32;
    localparam int ROW_W = 4;
    localparam int HOP_W = 3;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/sul_jump_engine_if.sv
// sul_jump_engine_if: request/result bundle between move generation and the jump engine
interface sul_jump_engine_if;
    import sul_jump_engine_pkg::*;
    logic start;
    logic [BOARD_W-1:0] board_own;
    logic [BOARD_W-1:0] board_opp;
    logic busy;
    logic done;
    logic [BOARD_W-1:0] land_mask;
    logic [HOP_W-1:0] hops;
    modport master (output start, board_own, board_opp, input busy, done, land_mask, hops);
    modport slave (input start, board_own, board_opp, output busy, done, land_mask, hops);
endinterface

// File: rtl/sul_jump_engine_sul.sv
// sul_jump_engine_sul: up-left board shift, each output row taken from the row below it
module sul_jump_engine_sul
    import sul_jump_engine_pkg::*;
(
    input  logic [BOARD_W-1:0] a,
    output logic [BOARD_W-1:0] s
);
    logic unused_bits;
    assign unused_bits = ^{a[24], a[16], a[8], a[3:0]};
    for (genvar r = 0; r < 8; r++) begin : g_r
        for (genvar c = 0; c < ROW_W; c++) begin : g_c
            // odd rows pull from one column to the right; their last column has no source
            if (r == 7 || (r % 2 == 1 && c == ROW_W - 1)) begin : g_zero
                assign s[ROW_W*r+c] = 1'b0;
            end else begin : g_map
                assign s[ROW_W*r+c] = a[ROW_W*(r+1)+c+(r%2)];
            end
        end
    end
endmodule

// File: rtl/sul_jump_engine.sv
// sul_jump_engine: iterates up-left single captures from latched boards, one hop per cycle,
// returning the union of landing squares and the hop count
module sul_jump_engine
    import sul_jump_engine_pkg::*;
#(
    parameter int MAX_HOPS = 7
) (
    input logic clock,
    input logic reset,
    sul_jump_engine_if.slave bus
);
    state_t state;
    logic [BOARD_W-1:0] opp_r, empty_r, frontier, mask_r, shift_f, cap, shift_c, land;
    logic [HOP_W-1:0] hops_r;
    logic busy_r, done_r;

    sul_jump_engine_sul u_sul_frontier (.a(frontier), .s(shift_f));
    sul_jump_engine_sul u_sul_cap (.a(cap), .s(shift_c));

    assign cap = shift_f & opp_r;
    assign land = shift_c & empty_r & ~mask_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.land_mask = mask_r;
    assign bus.hops = hops_r;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            opp_r <= '0;
            empty_r <= '0;
            frontier <= '0;
            mask_r <= '0;
            hops_r <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    opp_r <= bus.board_opp;
                    empty_r <= ~(bus.board_own | bus.board_opp);
                    frontier <= bus.board_own;
                    mask_r <= '0;
                    hops_r <= '0;
                    busy_r <= 1'b1;
                    state <= SCAN;
                end
                SCAN: if (land == '0 || hops_r == HOP_W'(MAX_HOPS)) begin
                    done_r <= 1'b1;
                    state <= DONE;
                end else begin
                    // captured pieces leave the board and their squares become landable
                    mask_r <= mask_r | land;
                    frontier <= land;
                    opp_r <= opp_r & ~cap;
                    empty_r <= empty_r | cap;
                    hops_r <= hops_r + 1'b1;
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sul_jump_engine.sv
// tb_sul_jump_engine: drives a MAX_HOPS=7 and a MAX_HOPS=1 engine in lockstep and checks both
// against a square-by-square capture model
module tb_sul_jump_engine;
    import sul_jump_engine_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic [31:0] b_own = '0;
    logic [31:0] b_opp = '0;
    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    sul_jump_engine_if bus7 ();
    sul_jump_engine_if bus1 ();
    assign bus7.start = start;
    assign bus7.board_own = b_own;
    assign bus7.board_opp = b_opp;
    assign bus1.start = start;
    assign bus1.board_own = b_own;
    assign bus1.board_opp = b_opp;

    sul_jump_engine #(.MAX_HOPS(7)) dut7 (.clock(clock), .reset(reset), .bus(bus7));
    sul_jump_engine #(.MAX_HOPS(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

    int o_lat[2], o_pulses[2];
    logic [31:0] o_mask[2], o_hold[2], em[2];
    logic [2:0] o_hops[2], eh[2];
    logic o_busy1[2], o_busy_end[2];

    // Move every piece one row up; odd destination rows sit half a square to the left
    function automatic logic [31:0] up_left(input logic [31:0] a);
        logic [31:0] s = '0;
        for (int i = 0; i < 32; i++) begin
            int r = i / 4;
            int c = i % 4;
            int ro = r - 1;
            int dc = (ro % 2 == 1) ? c - 1 : c;
            if (a[i] && ro >= 0 && dc >= 0) s[4*ro+dc] = 1'b1;
        end
        return s;
    endfunction

    task automatic model(input logic [31:0] own, input logic [31:0] opp, input int maxh,
                         output logic [31:0] m, output logic [2:0] h);
        logic [31:0] o = opp;
        logic [31:0] e = ~(own | opp);
        logic [31:0] f = own;
        logic [31:0] cp, l;
        bit stop = 0;
        int n = 0;
        m = '0;
        for (int k = 0; k < 8 && !stop; k++) begin
            cp = up_left(f) & o;
            l = up_left(cp) & e & ~m;
            if (l == 0 || n == maxh) stop = 1;
            else begin
                m = m | l;
                f = l;
                o = o & ~cp;
                e = e | cp;
                n++;
            end
        end
        h = 3'(n);
    endtask

    task automatic collect(input logic [31:0] own, input logic [31:0] opp, input bit extra);
        @(negedge clock);
        start = 1'b1;
        b_own = own;
        b_opp = opp;
        @(negedge clock);
        start = extra;
        for (int i = 0; i < 2; i++) begin
            o_lat[i] = 0;
            o_pulses[i] = 0;
        end
        for (int c = 1; c <= 12; c++) begin
            if (c == 3) start = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (c == 1) o_busy1[i] = i ? bus1.busy : bus7.busy;
                if (i ? bus1.done : bus7.done) begin
                    o_pulses[i]++;
                    if (o_lat[i] == 0) begin
                        o_lat[i] = c;
                        o_mask[i] = i ? bus1.land_mask : bus7.land_mask;
                        o_hops[i] = i ? bus1.hops : bus7.hops;
                    end
                end
                if (c == 12) begin
                    o_hold[i] = i ? bus1.land_mask : bus7.land_mask;
                    o_busy_end[i] = i ? bus1.busy : bus7.busy;
                end
            end
            if (c < 12) @(negedge clock);
        end
    endtask

    task automatic test_reset;
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({i ? bus1.busy : bus7.busy, i ? bus1.done : bus7.done,
                 i ? bus1.land_mask : bus7.land_mask, i ? bus1.hops : bus7.hops} !== 37'd0) begin
                errors++;
                $display("FAIL reset_state inst=%0d busy=%b done=%b mask=%h hops=%0d required all zero", i,
                         i ? bus1.busy : bus7.busy, i ? bus1.done : bus7.done,
                         i ? bus1.land_mask : bus7.land_mask, i ? bus1.hops : bus7.hops);
            end
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_directed;
        logic [31:0] t_own[5] = '{32'h0000_0200, 32'h0004_0000, 32'h0004_0200, 32'h0000_0100, 32'h0000_0004};
        logic [31:0] t_opp[5] = '{32'h0000_0010, 32'h0000_2010, 32'h0000_2010, 32'h0000_00f0, 32'h0000_0ff0};
        logic [31:0] t_m7[5] = '{32'h0000_0001, 32'h0000_0201, 32'h0000_0001, 32'h0, 32'h0};
        logic [31:0] t_m1[5] = '{32'h0000_0001, 32'h0000_0200, 32'h0000_0001, 32'h0, 32'h0};
        logic [2:0] t_h7[5] = '{3'd1, 3'd2, 3'd1, 3'd0, 3'd0};
        logic [2:0] t_h1[5] = '{3'd1, 3'd1, 3'd1, 3'd0, 3'd0};
        for (int k = 0; k < 5; k++) begin
            em[0] = t_m7[k]; eh[0] = t_h7[k];
            em[1] = t_m1[k]; eh[1] = t_h1[k];
            collect(t_own[k], t_opp[k], 1'b0);
            for (int i = 0; i < 2; i++) begin
                checks += 6;
                if (o_busy1[i] !== 1'b1) begin errors++; $display("FAIL dir_busy case=%0d inst=%0d got=%b want=1", k, i, o_busy1[i]); end
                if (o_lat[i] != 2 + int'(eh[i])) begin errors++; $display("FAIL dir_latency case=%0d inst=%0d got=%0d want=%0d", k, i, o_lat[i], 2 + int'(eh[i])); end
                if (o_pulses[i] != 1) begin errors++; $display("FAIL dir_pulses case=%0d inst=%0d got=%0d want=1", k, i, o_pulses[i]); end
                if (o_mask[i] !== em[i]) begin errors++; $display("FAIL dir_mask case=%0d inst=%0d got=%h want=%h", k, i, o_mask[i], em[i]); end
                if (o_hops[i] !== eh[i]) begin errors++; $display("FAIL dir_hops case=%0d inst=%0d got=%0d want=%0d", k, i, o_hops[i], eh[i]); end
                if (o_hold[i] !== em[i] || o_busy_end[i] !== 1'b0) begin errors++; $display("FAIL dir_hold case=%0d inst=%0d mask=%h busy=%b want mask=%h busy=0", k, i, o_hold[i], o_busy_end[i], em[i]); end
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] own, opp;
        for (int k = 0; k < 40; k++) begin
            own = $urandom & $urandom;
            opp = $urandom & ~own;
            model(own, opp, 7, em[0], eh[0]);
            model(own, opp, 1, em[1], eh[1]);
            collect(own, opp, 1'b0);
            for (int i = 0; i < 2; i++) begin
                checks += 6;
                if (o_busy1[i] !== 1'b1) begin errors++; $display("FAIL rnd_busy own=%h opp=%h inst=%0d got=%b want=1", own, opp, i, o_busy1[i]); end
                if (o_lat[i] != 2 + int'(eh[i])) begin errors++; $display("FAIL rnd_latency own=%h opp=%h inst=%0d got=%0d want=%0d", own, opp, i, o_lat[i], 2 + int'(eh[i])); end
                if (o_pulses[i] != 1) begin errors++; $display("FAIL rnd_pulses own=%h opp=%h inst=%0d got=%0d want=1", own, opp, i, o_pulses[i]); end
                if (o_mask[i] !== em[i]) begin errors++; $display("FAIL rnd_mask own=%h opp=%h inst=%0d got=%h want=%h", own, opp, i, o_mask[i], em[i]); end
                if (o_hops[i] !== eh[i]) begin errors++; $display("FAIL rnd_hops own=%h opp=%h inst=%0d got=%0d want=%0d", own, opp, i, o_hops[i], eh[i]); end
                if (o_hold[i] !== em[i] || o_busy_end[i] !== 1'b0) begin errors++; $display("FAIL rnd_hold own=%h opp=%h inst=%0d mask=%h busy=%b want mask=%h busy=0", own, opp, i, o_hold[i], o_busy_end[i], em[i]); end
            end
        end
    endtask

    task automatic test_start_ignored;
        model(32'h0004_0000, 32'h0000_2010, 7, em[0], eh[0]);
        model(32'h0004_0000, 32'h0000_2010, 1, em[1], eh[1]);
        collect(32'h0004_0000, 32'h0000_2010, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks += 3;
            if (o_pulses[i] != 1) begin errors++; $display("FAIL busy_start_pulses inst=%0d got=%0d want=1", i, o_pulses[i]); end
            if (o_mask[i] !== em[i] || o_hops[i] !== eh[i]) begin errors++; $display("FAIL busy_start_result inst=%0d mask=%h hops=%0d want mask=%h hops=%0d", i, o_mask[i], o_hops[i], em[i], eh[i]); end
            if (o_busy_end[i] !== 1'b0) begin errors++; $display("FAIL busy_start_rerun inst=%0d busy=%b want=0", i, o_busy_end[i]); end
        end
    endtask

    task automatic test_start_held;
        int c1 = 0, c2 = 0, lat;
        logic [15:0] bv = '0;
        model(32'h0004_0000, 32'h0000_2010, 7, em[0], eh[0]);
        lat = 2 + int'(eh[0]);
        @(negedge clock);
        start = 1'b1;
        b_own = 32'h0004_0000;
        b_opp = 32'h0000_2010;
        @(negedge clock);
        for (int c = 1; c <= 14; c++) begin
            if (bus7.done) begin
                if (c1 == 0) c1 = c;
                else if (c2 == 0) c2 = c;
            end
            bv[c] = bus7.busy;
            if (c < 14) @(negedge clock);
        end
        start = 1'b0;
        checks += 3;
        if (c1 != lat) begin errors++; $display("FAIL held_first_done got=%0d want=%0d", c1, lat); end
        if (c2 != 2 * lat + 1) begin errors++; $display("FAIL held_second_done got=%0d want=%0d", c2, 2 * lat + 1); end
        if (bv[lat+1] !== 1'b0 || bv[lat+2] !== 1'b1) begin errors++; $display("FAIL held_idle_gap busy=%b%b want=01", bv[lat+1], bv[lat+2]); end
        repeat (20) @(negedge clock);
        checks++;
        if (bus7.busy !== 1'b0 || bus1.busy !== 1'b0) begin errors++; $display("FAIL held_settle busy7=%b busy1=%b want=0", bus7.busy, bus1.busy); end
    endtask

    task automatic test_reset_mid_run;
        int pulses = 0;
        @(negedge clock);
        start = 1'b1;
        b_own = 32'h0004_0000;
        b_opp = 32'h0000_2010;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        checks++;
        if (bus7.hops !== 3'd1 || bus7.land_mask !== 32'h0000_0200) begin errors++; $display("FAIL mid_pre hops=%0d mask=%h want hops=1 mask=00000200", bus7.hops, bus7.land_mask); end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus7.busy, bus7.done, bus7.land_mask, bus7.hops, bus1.busy, bus1.done, bus1.land_mask, bus1.hops} !== 74'd0) begin
            errors++;
            $display("FAIL mid_reset busy=%b done=%b mask=%h hops=%0d required all zero", bus7.busy, bus7.done, bus7.land_mask, bus7.hops);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (bus7.done || bus1.done || bus7.busy) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL mid_no_done got=%0d active cycles want=0", pulses); end
        collect(32'h0004_0000, 32'h0000_2010, 1'b0);
        checks += 2;
        if (o_mask[0] !== 32'h0000_0201 || o_hops[0] !== 3'd2 || o_lat[0] != 4) begin errors++; $display("FAIL mid_rerun7 mask=%h hops=%0d lat=%0d want 00000201/2/4", o_mask[0], o_hops[0], o_lat[0]); end
        if (o_mask[1] !== 32'h0000_0200 || o_hops[1] !== 3'd1 || o_lat[1] != 3) begin errors++; $display("FAIL mid_rerun1 mask=%h hops=%0d lat=%0d want 00000200/1/3", o_mask[1], o_hops[1], o_lat[1]); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_ignored();
        test_start_held();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
